ci_stim_pulse_seq: RTL and testbench

- Biphasic pulse sequencer for the cochlear-implant current-stimulator H-bridge.
- Drives the four bridge switches (ano_top, ano_bot, cat_top, cat_bot) and the current-source enable.
- Sequence: dead time, phase 1, inter-phase gap, dead time, phase 2, optional discharge, rest. Repeats for a programmed pulse count.
- Sits between the register/config layer and the bridge pins inside the ci_stim_fpga wrapper.

---
 rtl/ci_stim_pulse_seq_pkg.sv | 33 +++
 rtl/ci_stim_pulse_seq_if.sv | 50 +++++
 rtl/ci_stim_phase_timer.sv | 38 +++
 rtl/ci_stim_pulse_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_ci_stim_pulse_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ci_stim_pulse_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ci_stim_pulse_seq_pkg
// Brief    : State encoding, bridge switch patterns and defaults shared by the
//            biphasic pulse sequencer files.
// Revision : 1.0 - initial release
// ============================================================================
package ci_stim_pulse_seq_pkg;

   localparam int DEAD_CYC_DEFAULT = 2;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_DEAD  = 3'd1;
   localparam state_t S_PH1   = 3'd2;
   localparam state_t S_IPG   = 3'd3;
   localparam state_t S_PH2   = 3'd4;
   localparam state_t S_DISCH = 3'd5;
   localparam state_t S_REST  = 3'd6;

   // Bit order {ano_top, ano_bot, cat_top, cat_bot}
   localparam logic [3:0] SW_OFF      = 4'b0000;
   localparam logic [3:0] SW_ANODIC   = 4'b1001;
   localparam logic [3:0] SW_CATHODIC = 4'b0110;
   localparam logic [3:0] SW_DISCH    = 4'b0101;

   function automatic logic [3:0] phase_pattern(input logic cathodic);
      return cathodic ? SW_CATHODIC : SW_ANODIC;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ci_stim_pulse_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ci_stim_pulse_seq_if
// Brief    : Control/config and bridge-gate bundle of the pulse sequencer.
//            CI_STIM_DISCHARGE_EN adds the discharge length field.
// Revision : 1.0 - initial release
// ============================================================================
interface ci_stim_pulse_seq_if #(
   parameter int CNT_W = 16,
   parameter int NP_W  = 8
);
   logic             i_start;
   logic             i_abort;
   logic             i_cfg_cath_first;
   logic [CNT_W-1:0] i_cfg_ph1_len;
   logic [CNT_W-1:0] i_cfg_ipg_len;
   logic [CNT_W-1:0] i_cfg_ph2_len;
   logic [CNT_W-1:0] i_cfg_rest_len;
   logic [NP_W-1:0]  i_cfg_npulse;
`ifdef CI_STIM_DISCHARGE_EN
   logic [CNT_W-1:0] i_cfg_disch_len;
`endif
   logic             o_ano_top;
   logic             o_ano_bot;
   logic             o_cat_top;
   logic             o_cat_bot;
   logic             o_curr_ena;
   logic             o_busy;
   logic             o_done;

   modport master (
`ifdef CI_STIM_DISCHARGE_EN
      output i_cfg_disch_len,
`endif
      output i_start, i_abort, i_cfg_cath_first, i_cfg_ph1_len, i_cfg_ipg_len,
             i_cfg_ph2_len, i_cfg_rest_len, i_cfg_npulse,
      input  o_ano_top, o_ano_bot, o_cat_top, o_cat_bot, o_curr_ena, o_busy, o_done
   );

   modport slave (
`ifdef CI_STIM_DISCHARGE_EN
      input  i_cfg_disch_len,
`endif
      input  i_start, i_abort, i_cfg_cath_first, i_cfg_ph1_len, i_cfg_ipg_len,
             i_cfg_ph2_len, i_cfg_rest_len, i_cfg_npulse,
      output o_ano_top, o_ano_bot, o_cat_top, o_cat_bot, o_curr_ena, o_busy, o_done
   );

endinterface
`default_nettype wire

// File: rtl/ci_stim_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : ci_stim_phase_timer
// Brief    : Loadable down-counter for state durations; a zero length loads
//            as a one-cycle duration. Terminal count when the counter is 0.
// Revision : 1.0 - initial release
// ============================================================================
module ci_stim_phase_timer #(
   parameter int CNT_W = 16
) (
   input  wire             i_clk,
   input  wire             i_rst_n,
   input  wire             i_load,
   input  wire [CNT_W-1:0] i_len,
   output logic            o_tc
);

   logic [CNT_W-1:0] r_count;
   logic             w_len_zero;
   logic [CNT_W-1:0] w_load_val;

   assign w_len_zero = (i_len == '0);
   assign w_load_val = w_len_zero ? '0 : (i_len - CNT_W'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= w_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ci_stim_pulse_seq.sv
`default_nettype none
// ============================================================================
// Module   : ci_stim_pulse_seq
// Brief    : Biphasic H-bridge pulse sequencer; dead time, two phases, gap,
//            optional discharge (CI_STIM_DISCHARGE_EN) and rest per pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ci_stim_pulse_seq
   import ci_stim_pulse_seq_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int NP_W     = 8,
   parameter int DEAD_CYC = DEAD_CYC_DEFAULT
) (
   input  wire                i_clk,
   input  wire                i_rst_n,
   ci_stim_pulse_seq_if.slave bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   state_t           r_dead_next;
   state_t           w_dead_next_nxt;
   state_t           w_eop_state;
   state_t           w_after_disch;
   state_t           w_after_ph2;
   logic             r_cath;
   logic             r_inf;
   logic [CNT_W-1:0] r_ph1_len;
   logic [CNT_W-1:0] r_ipg_len;
   logic [CNT_W-1:0] r_ph2_len;
   logic [CNT_W-1:0] r_rest_len;
   logic [NP_W-1:0]  r_pulse_cnt;
   logic             w_start_acc;
   logic             w_eop;
   logic             w_tc;
   logic             w_load;
   logic [CNT_W-1:0] w_load_len;
   logic             w_disch_skip;
   logic [3:0]       r_sw;
   logic [3:0]       w_sw_nxt;
   logic             r_curr_ena;
   logic             w_curr_ena_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;

`ifdef CI_STIM_DISCHARGE_EN
   logic [CNT_W-1:0] r_disch_len;
   assign w_disch_skip = (r_disch_len == '0);
`else
   assign w_disch_skip = 1'b1;
`endif

   // End-of-pulse point: next pulse or train complete; zero-length states skipped
   assign w_eop_state   = (r_inf || (r_pulse_cnt != NP_W'(1))) ? S_DEAD : S_IDLE;
   assign w_after_disch = (r_rest_len == '0) ? w_eop_state : S_REST;
   assign w_after_ph2   = w_disch_skip ? w_after_disch : S_DEAD;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_dead_next <= S_IDLE;
         r_sw        <= SW_OFF;
         r_curr_ena  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_dead_next <= w_dead_next_nxt;
         r_sw        <= w_sw_nxt;
         r_curr_ena  <= w_curr_ena_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_dead_next_nxt = r_dead_next;
      w_start_acc     = 1'b0;
      w_eop           = 1'b0;
      if (bus.i_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  w_start_acc     = 1'b1;
                  w_state_nxt     = S_DEAD;
                  w_dead_next_nxt = S_PH1;
               end
            end
            S_DEAD: begin
               if (w_tc) w_state_nxt = r_dead_next;
            end
            S_PH1: begin
               if (w_tc) begin
                  w_state_nxt     = (r_ipg_len == '0) ? S_DEAD : S_IPG;
                  w_dead_next_nxt = S_PH2;
               end
            end
            S_IPG: begin
               if (w_tc) begin
                  w_state_nxt     = S_DEAD;
                  w_dead_next_nxt = S_PH2;
               end
            end
            S_PH2: begin
               if (w_tc) begin
                  w_state_nxt     = w_after_ph2;
                  w_eop           = w_disch_skip && (r_rest_len == '0);
                  w_dead_next_nxt = w_disch_skip ? S_PH1 : S_DISCH;
               end
            end
`ifdef CI_STIM_DISCHARGE_EN
            S_DISCH: begin
               if (w_tc) begin
                  w_state_nxt     = w_after_disch;
                  w_eop           = (r_rest_len == '0);
                  w_dead_next_nxt = S_PH1;
               end
            end
`endif
            S_REST: begin
               if (w_tc) begin
                  w_state_nxt     = w_eop_state;
                  w_eop           = 1'b1;
                  w_dead_next_nxt = S_PH1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered alongside it
   always_comb begin
      w_sw_nxt       = SW_OFF;
      w_curr_ena_nxt = 1'b0;
      w_busy_nxt     = (w_state_nxt != S_IDLE);
      w_done_nxt     = w_eop && (w_eop_state == S_IDLE);
      case (w_state_nxt)
         S_PH1: begin
            w_sw_nxt       = phase_pattern(r_cath);
            w_curr_ena_nxt = 1'b1;
         end
         S_PH2: begin
            w_sw_nxt       = phase_pattern(!r_cath);
            w_curr_ena_nxt = 1'b1;
         end
`ifdef CI_STIM_DISCHARGE_EN
         S_DISCH: w_sw_nxt = SW_DISCH;
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_load_len = CNT_W'(DEAD_CYC);
      case (w_state_nxt)
         S_PH1:   w_load_len = r_ph1_len;
         S_IPG:   w_load_len = r_ipg_len;
         S_PH2:   w_load_len = r_ph2_len;
         S_REST:  w_load_len = r_rest_len;
`ifdef CI_STIM_DISCHARGE_EN
         S_DISCH: w_load_len = r_disch_len;
`endif
         default: ;
      endcase
   end

   // No state ever transitions into itself, so any change of state is an entry
   assign w_load = (w_state_nxt != r_state);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cath      <= 1'b0;
         r_inf       <= 1'b0;
         r_ph1_len   <= '0;
         r_ipg_len   <= '0;
         r_ph2_len   <= '0;
         r_rest_len  <= '0;
         r_pulse_cnt <= '0;
`ifdef CI_STIM_DISCHARGE_EN
         r_disch_len <= '0;
`endif
      end else if (w_start_acc) begin
         r_cath      <= bus.i_cfg_cath_first;
         r_inf       <= (bus.i_cfg_npulse == '0);
         r_ph1_len   <= bus.i_cfg_ph1_len;
         r_ipg_len   <= bus.i_cfg_ipg_len;
         r_ph2_len   <= bus.i_cfg_ph2_len;
         r_rest_len  <= bus.i_cfg_rest_len;
         r_pulse_cnt <= bus.i_cfg_npulse;
`ifdef CI_STIM_DISCHARGE_EN
         r_disch_len <= bus.i_cfg_disch_len;
`endif
      end else if (w_eop && !r_inf) begin
         r_pulse_cnt <= r_pulse_cnt - NP_W'(1);
      end
   end

   ci_stim_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_len   (w_load_len),
      .o_tc    (w_tc)
   );

   assign bus.o_ano_top  = r_sw[3];
   assign bus.o_ano_bot  = r_sw[2];
   assign bus.o_cat_top  = r_sw[1];
   assign bus.o_cat_bot  = r_sw[0];
   assign bus.o_curr_ena = r_curr_ena;
   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ci_stim_pulse_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ci_stim_pulse_seq
// Brief    : Self-checking bench for ci_stim_pulse_seq against a cycle
//            schedule model built from the pulse-train rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ci_stim_pulse_seq;

   localparam int CNT_W    = 16;
   localparam int NP_W     = 8;
   localparam int DEAD_CYC = 2;

   // {ano_top, ano_bot, cat_top, cat_bot, curr_ena, busy, done}
   localparam logic [6:0] V_IDLE = 7'b0000_0_0_0;
   localparam logic [6:0] V_OFF  = 7'b0000_0_1_0;
   localparam logic [6:0] V_ANO  = 7'b1001_1_1_0;
   localparam logic [6:0] V_CAT  = 7'b0110_1_1_0;
   localparam logic [6:0] V_DIS  = 7'b0101_0_1_0;
   localparam logic [6:0] V_DONE = 7'b0000_0_0_1;

   typedef struct {
      bit cath;
      int ph1;
      int ipg;
      int ph2;
      int rest;
      int np;
      int disch;
   } cfg_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [6:0] exp_q[$];

   ci_stim_pulse_seq_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus ();

   ci_stim_pulse_seq #(
      .CNT_W    (CNT_W),
      .NP_W     (NP_W),
      .DEAD_CYC (DEAD_CYC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] obs();
      return {bus.o_ano_top, bus.o_ano_bot, bus.o_cat_top, bus.o_cat_bot,
              bus.o_curr_ena, bus.o_busy, bus.o_done};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         n_tests++;
         if ((bus.o_ano_top & bus.o_ano_bot) | (bus.o_cat_top & bus.o_cat_bot)) begin
            n_fail++;
            $display("FAIL overlap at %0t: gates=%b required no same-leg pair", $time, obs());
         end
      end
   end

   task automatic push_n(input logic [6:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   // One entry per cycle after the start edge; a finite train ends in a done cycle
   task automatic build_exp(input cfg_t c, input int min_len);
      int pulses;
      pulses = 0;
      exp_q.delete();
      do begin
         push_n(V_OFF, DEAD_CYC);
         push_n(c.cath ? V_CAT : V_ANO, (c.ph1 == 0) ? 1 : c.ph1);
         push_n(V_OFF, c.ipg);
         push_n(V_OFF, DEAD_CYC);
         push_n(c.cath ? V_ANO : V_CAT, (c.ph2 == 0) ? 1 : c.ph2);
         if (c.disch > 0) begin
            push_n(V_OFF, DEAD_CYC);
            push_n(V_DIS, c.disch);
         end
         push_n(V_OFF, c.rest);
         pulses++;
      end while ((c.np == 0) ? (exp_q.size() < min_len) : (pulses < c.np));
      if (c.np != 0) exp_q.push_back(V_DONE);
   endtask

   task automatic apply_cfg(input cfg_t c);
      bus.i_cfg_cath_first = c.cath;
      bus.i_cfg_ph1_len    = CNT_W'(c.ph1);
      bus.i_cfg_ipg_len    = CNT_W'(c.ipg);
      bus.i_cfg_ph2_len    = CNT_W'(c.ph2);
      bus.i_cfg_rest_len   = CNT_W'(c.rest);
      bus.i_cfg_npulse     = NP_W'(c.np);
`ifdef CI_STIM_DISCHARGE_EN
      bus.i_cfg_disch_len  = CNT_W'(c.disch);
`endif
   endtask

   function automatic cfg_t rand_cfg(input int np_min);
      cfg_t c;
      c.cath  = 1'($urandom_range(0, 1));
      c.ph1   = int'($urandom_range(0, 5));
      c.ipg   = int'($urandom_range(0, 3));
      c.ph2   = int'($urandom_range(0, 5));
      c.rest  = int'($urandom_range(0, 4));
      c.np    = int'($urandom_range(np_min, 3));
`ifdef CI_STIM_DISCHARGE_EN
      c.disch = int'($urandom_range(0, 4));
`else
      c.disch = 0;
`endif
      return c;
   endfunction

   function automatic cfg_t plan_cfg(input bit cath);
      cfg_t c;
      c.cath = cath; c.ph1 = 3; c.ipg = 2; c.ph2 = 3; c.rest = 4; c.np = 2; c.disch = 0;
      return c;
   endfunction

   task automatic start_train(input cfg_t c);
      @(negedge clk);
      apply_cfg(c);
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   // noise: random start pulses and config changes while busy, which must be ignored
   task automatic run_train(input string name, input cfg_t c, input bit noise, input int abort_at);
      int n;
      build_exp(c, abort_at);
      n = (abort_at > 0 && abort_at < exp_q.size()) ? abort_at : exp_q.size();
      start_train(c);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== exp_q[k]) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs=%b required=%b", name, k + 1, obs(), exp_q[k]);
         end
         if (noise && k < exp_q.size() - 1) begin
            bus.i_start = 1'($urandom_range(0, 1));
            apply_cfg(rand_cfg(0));
         end else begin
            bus.i_start = 1'b0;
         end
      end
      bus.i_start = 1'b0;
      if (abort_at > 0) begin
         bus.i_abort = 1'b1;
         @(posedge clk);
         #1;
         bus.i_abort = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== V_IDLE) begin
            n_fail++;
            $display("FAIL %s idle_after: outputs=%b required=%b", name, obs(), V_IDLE);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%b required=%b", obs(), V_IDLE);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs() !== V_IDLE) begin
         n_fail++;
         $display("FAIL reset_release: outputs=%b required=%b", obs(), V_IDLE);
      end
   endtask

   task automatic test_anodic_first();
      run_train("anodic_first", plan_cfg(1'b0), 1'b0, 0);
   endtask

   task automatic test_cathodic_first();
      run_train("cathodic_first", plan_cfg(1'b1), 1'b0, 0);
   endtask

   task automatic test_zero_lengths();
      cfg_t c;
      c = plan_cfg(1'b0);
      c.ipg = 0; c.rest = 0; c.ph1 = 0; c.np = 3;
      run_train("zero_lengths", c, 1'b0, 0);
      c.ph2 = 0; c.cath = 1'b1; c.np = 1;
      run_train("zero_ph2", c, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) run_train("random", rand_cfg(1), 1'b1, 0);
      for (int i = 0; i < 4; i++)
         run_train("random_abort", rand_cfg(0), 1'b0, int'($urandom_range(1, 20)));
   endtask

   task automatic test_continuous_abort();
      cfg_t c;
      c = plan_cfg(1'b0);
      c.np = 0;
      run_train("continuous", c, 1'b0, 1000);
   endtask

   task automatic test_abort_start();
      @(negedge clk);
      apply_cfg(plan_cfg(1'b0));
      bus.i_start = 1'b1;
      bus.i_abort = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== V_IDLE) begin
            n_fail++;
            $display("FAIL abort_over_start: outputs=%b required=%b", obs(), V_IDLE);
         end
      end
   endtask

   task automatic test_reset_mid();
      cfg_t c;
      c = plan_cfg(1'b0);
      build_exp(c, 0);
      start_train(c);
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== exp_q[k]) begin
            n_fail++;
            $display("FAIL reset_mid_pre cycle %0d: outputs=%b required=%b", k + 1, obs(), exp_q[k]);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs() !== V_IDLE) begin
         n_fail++;
         $display("FAIL reset_mid_async: outputs=%b required=%b", obs(), V_IDLE);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_train("after_reset", c, 1'b0, 0);
   endtask

`ifdef CI_STIM_DISCHARGE_EN
   task automatic test_discharge();
      cfg_t c;
      c = plan_cfg(1'b0);
      c.disch = 5;
      run_train("discharge", c, 1'b0, 0);
      c.disch = 0; c.rest = 0; c.np = 1;
      run_train("discharge_skip", c, 1'b0, 0);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      apply_cfg(plan_cfg(1'b0));
      test_reset();
      test_anodic_first();
      test_cathodic_first();
      test_zero_lengths();
      test_abort_start();
      test_continuous_abort();
      test_reset_mid();
`ifdef CI_STIM_DISCHARGE_EN
      test_discharge();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
